// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file sequencer.
// Opcodes, sequencer states and default widths live here.
package regfile_pkg;

   localparam int RF_DATA_W   = 32;
   localparam int RF_ADDR_W   = 5;
   localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_AND   = 3'd2,
      OP_OR    = 3'd3,
      OP_XOR   = 3'd4,
      OP_LOADI = 3'd5,
      OP_MOV   = 3'd6,
      OP_RSVD  = 3'd7
   } rf_op_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WRITE = 3'd3,
      ST_SWEEP = 3'd4
   } rf_seq_state_t;

endpackage

// File: rtl/regfile_alu.sv
// Combinational result unit for register-to-register operations.
// Reserved opcode yields zero so the write-back stays well defined.
module regfile_alu
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W
) (
   input  rf_op_t            op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result
);

   // Select the operation result; add/sub wrap with carry dropped.
   always_comb begin
      result = '0;
      case (op)
         OP_ADD:   result = a + b;
         OP_SUB:   result = a - b;
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_LOADI: result = imm;
         OP_MOV:   result = a;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/regfile_seq.sv
// Command sequencer driving a 2R/1W register file.
// Runs read/exec/write per command and a zeroing sweep.
module regfile_seq
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [DATA_W-1:0] cmd_imm,
   input  logic              sweep_start,
   output logic [ADDR_W-1:0] rf_readaddr1,
   output logic [ADDR_W-1:0] rf_readaddr2,
   input  logic [DATA_W-1:0] rf_read1,
   input  logic [DATA_W-1:0] rf_read2,
   output logic [ADDR_W-1:0] rf_writeaddr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_write_cntrl,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy
);

   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

   rf_seq_state_t     state;
   rf_seq_state_t     state_nxt;
   rf_op_t            op;
   logic [ADDR_W-1:0] rd;
   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] alu_res;
   logic [ADDR_W-1:0] cnt;

   regfile_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op     (op),
      .a      (opa),
      .b      (opb),
      .imm    (imm),
      .result (alu_res)
   );

   // State register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; sweep request has priority over a command.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (sweep_start)    state_nxt = ST_SWEEP;
            else if (cmd_valid) state_nxt = ST_READ;
         end
         ST_READ:  state_nxt = ST_EXEC;
         ST_EXEC:  state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = ST_IDLE;
         ST_SWEEP: begin
            if (cnt == LAST) state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Command latch, operand capture, result and sweep counter.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         op     <= OP_ADD;
         rd     <= '0;
         rs1    <= '0;
         rs2    <= '0;
         imm    <= '0;
         opa    <= '0;
         opb    <= '0;
         result <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (sweep_start) begin
                  cnt <= '0;
               end else if (cmd_valid) begin
                  op  <= rf_op_t'(cmd_op);
                  rd  <= cmd_rd;
                  rs1 <= cmd_rs1;
                  rs2 <= cmd_rs2;
                  imm <= cmd_imm;
               end
            end
            ST_READ: begin
               opa <= rf_read1;
               opb <= rf_read2;
            end
            ST_EXEC:  result <= alu_res;
            ST_SWEEP: cnt <= cnt + 1'b1;
            default:  ;
         endcase
      end
   end

   // rs1/rs2 only change on accept, so they double as held read addresses.
   assign rf_readaddr1   = rs1;
   assign rf_readaddr2   = rs2;
   assign cmd_ready      = (state == ST_IDLE);
   assign busy           = (state != ST_IDLE);
   assign rsp_valid      = (state == ST_WRITE);
   assign rsp_data       = rsp_valid ? result : '0;
   assign rf_write_cntrl = (state == ST_WRITE) || (state == ST_SWEEP);
   assign rf_writeaddr   = (state == ST_SWEEP) ? cnt : rd;
   assign rf_write_data  = (state == ST_WRITE) ? result : '0;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural register file.
// Table vectors plus hand sequences for sweep and reset aborts.
module tb_regfile_seq;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [4:0]  cmd_rd = '0;
   logic [4:0]  cmd_rs1 = '0;
   logic [4:0]  cmd_rs2 = '0;
   logic [31:0] cmd_imm = '0;
   logic        sweep_start = 1'b0;
   logic [4:0]  rf_readaddr1;
   logic [4:0]  rf_readaddr2;
   logic [31:0] rf_read1;
   logic [31:0] rf_read2;
   logic [4:0]  rf_writeaddr;
   logic [31:0] rf_write_data;
   logic        rf_write_cntrl;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        busy;

   regfile_seq dut (
      .clk            (clk),
      .clr            (clr),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_rd         (cmd_rd),
      .cmd_rs1        (cmd_rs1),
      .cmd_rs2        (cmd_rs2),
      .cmd_imm        (cmd_imm),
      .sweep_start    (sweep_start),
      .rf_readaddr1   (rf_readaddr1),
      .rf_readaddr2   (rf_readaddr2),
      .rf_read1       (rf_read1),
      .rf_read2       (rf_read2),
      .rf_writeaddr   (rf_writeaddr),
      .rf_write_data  (rf_write_data),
      .rf_write_cntrl (rf_write_cntrl),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Behavioural REGISTERS: combinational reads, clocked write, no reset.
   logic [31:0] regs [32];
   int          wcount = 0;

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 | i;
   end

   always @(posedge clk) begin
      if (rf_write_cntrl === 1'b1) begin
         regs[rf_writeaddr] <= rf_write_data;
         wcount <= wcount + 1;
      end
   end

   assign rf_read1 = regs[rf_readaddr1];
   assign rf_read2 = regs[rf_readaddr2];

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [14];
   time  acc_t;
   time  last_acc;

   // Issue one command from a negedge in IDLE; ends on the IDLE negedge.
   task automatic do_cmd(input vec_t v);
      int n;
      int w0;
      n = 0;
      while (!cmd_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
      cmd_op    = v.op;
      cmd_rd    = v.rd;
      cmd_rs1   = v.rs1;
      cmd_rs2   = v.rs2;
      cmd_imm   = v.imm;
      cmd_valid = 1'b1;
      w0 = wcount;
      @(posedge clk);
      acc_t = $time;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_latency", 32'(n), 32'd3);
      chk("rsp_data", rsp_data, v.exp);
      chk("write_addr", 32'(rf_writeaddr), 32'(v.rd));
      chk("write_data", rf_write_data, v.exp);
      @(negedge clk);
      chk("reg_value", regs[v.rd], v.exp);
      chk("write_count", 32'(wcount - w0), 32'd1);
      chk("ready_after", 32'(cmd_ready), 32'd1);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_ready"}, 32'(cmd_ready), 32'd1);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_wcntrl"}, 32'(rf_write_cntrl), 32'd0);
      chk({nm, "_rsp"}, 32'(rsp_valid), 32'd0);
      chk({nm, "_waddr"}, 32'(rf_writeaddr), 32'd0);
      chk({nm, "_wdata"}, rf_write_data, 32'd0);
      chk({nm, "_raddr1"}, 32'(rf_readaddr1), 32'd0);
   endtask

   vec_t cq [3];
   vec_t tmp;

   initial begin
      int n, k, rc, w0;
      vt[0]  = '{3'd5, 5'd25, 5'd0,  5'd0,  32'd25, 32'd25};
      vt[1]  = '{3'd5, 5'd28, 5'd0,  5'd0,  32'd28, 32'd28};
      vt[2]  = '{3'd0, 5'd16, 5'd28, 5'd25, 32'd0,  32'd53};
      vt[3]  = '{3'd5, 5'd0,  5'd0,  5'd0,  32'd0,  32'd0};
      vt[4]  = '{3'd5, 5'd2,  5'd0,  5'd0,  32'd1,  32'd1};
      vt[5]  = '{3'd1, 5'd1,  5'd0,  5'd2,  32'd0,  32'hFFFF_FFFF};
      vt[6]  = '{3'd0, 5'd3,  5'd1,  5'd2,  32'd0,  32'd0};
      vt[7]  = '{3'd5, 5'd5,  5'd0,  5'd0,  32'd7,  32'd7};
      vt[8]  = '{3'd0, 5'd5,  5'd5,  5'd5,  32'd0,  32'd14};
      vt[9]  = '{3'd2, 5'd6,  5'd28, 5'd25, 32'd0,  32'd24};
      vt[10] = '{3'd3, 5'd7,  5'd28, 5'd25, 32'd0,  32'd29};
      vt[11] = '{3'd4, 5'd8,  5'd28, 5'd25, 32'd0,  32'd5};
      vt[12] = '{3'd6, 5'd10, 5'd16, 5'd0,  32'd9,  32'd53};
      vt[13] = '{3'd7, 5'd11, 5'd1,  5'd1,  32'd9,  32'd0};

      // Power-on reset
      @(negedge clk);
      chk_reset_outs("por");
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);

      // Table vectors; first three must be accepted 4 cycles apart
      last_acc = 0;
      for (int i = 0; i < 14; i++) begin
         do_cmd(vt[i]);
         if (i == 1 || i == 2)
            chk("accept_spacing", 32'((acc_t - last_acc) / 10), 32'd4);
         last_acc = acc_t;
      end
      chk("r16_readback", regs[16], 32'd53);

      // cmd_valid held high with changing commands
      cq[0] = '{3'd5, 5'd5,  5'd0, 5'd0,  32'd7, 32'd7};
      cq[1] = '{3'd0, 5'd5,  5'd5, 5'd5,  32'd0, 32'd14};
      cq[2] = '{3'd4, 5'd13, 5'd5, 5'd28, 32'd0, 32'd18};
      k = 0;
      rc = 0;
      w0 = wcount;
      for (int c = 0; c < 40; c++) begin
         if (busy) chk("ready_while_busy", 32'(cmd_ready), 32'd0);
         if (rsp_valid) begin
            if (rc < 3) begin
               chk("stream_rsp", rsp_data, cq[rc].exp);
               chk("stream_rd", 32'(rf_writeaddr), 32'(cq[rc].rd));
            end
            rc++;
         end
         if (cmd_ready) begin
            if (k < 3) begin
               tmp = cq[k];
               cmd_op    = tmp.op;
               cmd_rd    = tmp.rd;
               cmd_rs1   = tmp.rs1;
               cmd_rs2   = tmp.rs2;
               cmd_imm   = tmp.imm;
               cmd_valid = 1'b1;
               k++;
            end else begin
               cmd_valid = 1'b0;
               if (rc >= 3) break;
            end
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("stream_rsp_count", 32'(rc), 32'd3);
      chk("stream_writes", 32'(wcount - w0), 32'd3);
      chk("stream_r5", regs[5], 32'd14);
      chk("stream_r13", regs[13], 32'd18);

      // Sweep and command together: sweep wins
      @(negedge clk);
      w0 = wcount;
      sweep_start = 1'b1;
      cmd_valid   = 1'b1;
      cmd_op      = 3'd5;
      cmd_rd      = 5'd20;
      cmd_imm     = 32'd77;
      @(negedge clk);
      sweep_start = 1'b0;
      cmd_valid   = 1'b0;
      chk("sweep_holds_cmd", 32'(cmd_ready), 32'd0);
      for (int i = 0; i < 32; i++) begin
         if (rf_write_cntrl !== 1'b1 || rf_writeaddr !== 5'(i) ||
             rf_write_data !== 32'd0 || rsp_valid !== 1'b0 ||
             busy !== 1'b1) begin
            chk("sweep_cycle_addr", 32'(rf_writeaddr), 32'(i));
            chk("sweep_cycle_wr", 32'(rf_write_cntrl), 32'd1);
            chk("sweep_cycle_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            vectors++;
         end
         @(negedge clk);
      end
      chk("sweep_done_busy", 32'(busy), 32'd0);
      chk("sweep_writes", 32'(wcount - w0), 32'd32);
      for (int i = 0; i < 32; i++) chk("sweep_zero", regs[i], 32'd0);

      // Reset during EXEC of LOADI r9=99
      do_cmd('{3'd5, 5'd10, 5'd0, 5'd0, 32'hAA, 32'hAA});
      do_cmd('{3'd5, 5'd12, 5'd0, 5'd0, 32'h1234, 32'h1234});
      do_cmd('{3'd5, 5'd9, 5'd0, 5'd0, 32'h55, 32'h55});
      w0 = wcount;
      cmd_op    = 3'd5;
      cmd_rd    = 5'd9;
      cmd_imm   = 32'd99;
      cmd_valid = 1'b1;
      @(posedge clk);
      cmd_valid = 1'b0;
      @(posedge clk);
      #2 clr = 1'b1;
      #1 chk_reset_outs("exec_abort");
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("exec_abort_r9", regs[9], 32'h55);
      chk("exec_abort_idle", 32'(busy), 32'd0);
      chk("exec_abort_writes", 32'(wcount - w0), 32'd0);

      // Reset during sweep at counter 10
      w0 = wcount;
      sweep_start = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0;
      n = 0;
      while (rf_writeaddr !== 5'd10 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("sweep_reach_10", 32'(rf_writeaddr), 32'd10);
      clr = 1'b1;
      #1 chk_reset_outs("sweep_abort");
      @(negedge clk);
      clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("sweep_abort_idle", 32'(busy), 32'd0);
      chk("sweep_abort_ready", 32'(cmd_ready), 32'd1);
      chk("sweep_abort_r9", regs[9], 32'd0);
      chk("sweep_abort_r10", regs[10], 32'hAA);
      chk("sweep_abort_r12", regs[12], 32'h1234);
      chk("sweep_abort_writes", 32'(wcount - w0), 32'd10);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
